// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-port data memory
//
// Purpose:
//   Shares one single-port data memory between the core load/store path and a
//   debug/program-loader port. Each access runs IDLE -> ACCESS (MEM_LAT cycles)
//   -> DONE. Only one transaction is outstanding at a time. Ties are broken
//   round-robin, and after reset the core wins the first tie.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   core_req/we/addr/wdata          core request, held until core_done
//   core_gnt, core_done, core_rdata core grant (ACCESS), done pulse, read data
//   dbg_*                           same set of signals for the debug port
//   mem_en/we/addr/wdata            memory command, zero outside ACCESS
//   mem_rdata                       memory read data, valid in last ACCESS cycle
//   busy                            state != IDLE
module dmem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_done,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_done,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_DBG  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   // owner_q is the current owner while busy and the last owner while idle;
   // it resets to DBG so the core wins the first tie.
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
   logic                pick_dbg;

   // Debug wins when it is the only requester, or on a tie when the core
   // had the previous grant.
   assign pick_dbg = dbg_req && (!core_req || (owner_q == OWN_CORE));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (core_req || dbg_req) state_d = S_ACCESS;
         S_ACCESS: if (cnt_q == '0) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next values: grant latch, latency counter, read capture
   always_comb begin
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      core_rdata_d = core_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (core_req || dbg_req) begin
               owner_d = pick_dbg ? OWN_DBG : OWN_CORE;
               we_d    = pick_dbg ? dbg_we    : core_we;
               addr_d  = pick_dbg ? dbg_addr  : core_addr;
               wdata_d = pick_dbg ? dbg_wdata : core_wdata;
               cnt_d   = CNT_W'(MEM_LAT - 1);
            end
         end
         S_ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!we_q) begin
               if (owner_q == OWN_DBG) dbg_rdata_d  = mem_rdata;
               else                    core_rdata_d = mem_rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         owner_q      <= OWN_DBG;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         core_rdata_q <= core_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   // Output logic: everything is decoded from registered state, so an
   // asynchronous reset clears the outputs immediately.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      core_gnt  = 1'b0;
      dbg_gnt   = 1'b0;
      core_done = 1'b0;
      dbg_done  = 1'b0;
      busy      = (state_q != S_IDLE);
      case (state_q)
         S_ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            core_gnt  = (owner_q == OWN_CORE);
            dbg_gnt   = (owner_q == OWN_DBG);
         end
         S_DONE: begin
            core_done = (owner_q == OWN_CORE);
            dbg_done  = (owner_q == OWN_DBG);
         end
         default: ;
      endcase
   end

   assign core_rdata = core_rdata_q;
   assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter at MEM_LAT 1, 2 and 3
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        core_req, core_we, dbg_req, dbg_we;
   logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata, mem_rdata;

   // index 0: MEM_LAT=1, 1: MEM_LAT=2, 2: MEM_LAT=3
   logic [2:0]  core_gnt_o, core_done_o, dbg_gnt_o, dbg_done_o, mem_en_o, mem_we_o, busy_o;
   logic [31:0] core_rdata_o [3];
   logic [31:0] dbg_rdata_o  [3];
   logic [31:0] mem_addr_o   [3];
   logic [31:0] mem_wdata_o  [3];

   int n_checks = 0;
   int n_fail   = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt_o[0]), .core_done(core_done_o[0]), .core_rdata(core_rdata_o[0]),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt_o[0]), .dbg_done(dbg_done_o[0]), .dbg_rdata(dbg_rdata_o[0]),
      .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
      .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata), .busy(busy_o[0])
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u2 (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt_o[1]), .core_done(core_done_o[1]), .core_rdata(core_rdata_o[1]),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt_o[1]), .dbg_done(dbg_done_o[1]), .dbg_rdata(dbg_rdata_o[1]),
      .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
      .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata), .busy(busy_o[1])
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt_o[2]), .core_done(core_done_o[2]), .core_rdata(core_rdata_o[2]),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt_o[2]), .dbg_done(dbg_done_o[2]), .dbg_rdata(dbg_rdata_o[2]),
      .mem_en(mem_en_o[2]), .mem_we(mem_we_o[2]), .mem_addr(mem_addr_o[2]),
      .mem_wdata(mem_wdata_o[2]), .mem_rdata(mem_rdata), .busy(busy_o[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
      mem_rdata = '0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      core_req = 1'b1; dbg_req = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({core_gnt_o[i], core_done_o[i], dbg_gnt_o[i], dbg_done_o[i], mem_en_o[i], mem_we_o[i], busy_o[i]} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl[%0d]: got %b want 0", i,
               {core_gnt_o[i], core_done_o[i], dbg_gnt_o[i], dbg_done_o[i], mem_en_o[i], mem_we_o[i], busy_o[i]});
         end
         n_checks++;
         if ((mem_addr_o[i] | mem_wdata_o[i] | core_rdata_o[i] | dbg_rdata_o[i]) !== 32'h0) begin
            n_fail++; $display("FAIL reset_data[%0d]: got addr %h wdata %h crd %h drd %h want 0", i,
               mem_addr_o[i], mem_wdata_o[i], core_rdata_o[i], dbg_rdata_o[i]);
         end
      end
      do_reset();
   endtask

   task automatic test_core_read();
      do_reset();
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
      tick();
      n_checks++; if (mem_en_o[0] !== 1'b1) begin n_fail++; $display("FAIL rd_en: got %b want 1", mem_en_o[0]); end
      n_checks++; if (mem_addr_o[0] !== 32'h10) begin n_fail++; $display("FAIL rd_addr: got %h want 10", mem_addr_o[0]); end
      n_checks++; if ({core_gnt_o[0], dbg_gnt_o[0], mem_we_o[0], core_done_o[0]} !== 4'b1000) begin
         n_fail++; $display("FAIL rd_gnt: got %b want 1000", {core_gnt_o[0], dbg_gnt_o[0], mem_we_o[0], core_done_o[0]}); end
      tick();
      n_checks++; if (core_done_o[0] !== 1'b1) begin n_fail++; $display("FAIL rd_done: got %b want 1", core_done_o[0]); end
      n_checks++; if (core_rdata_o[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", core_rdata_o[0]); end
      n_checks++; if ({mem_en_o[0], core_gnt_o[0], busy_o[0]} !== 3'b001) begin
         n_fail++; $display("FAIL rd_donestate: got %b want 001", {mem_en_o[0], core_gnt_o[0], busy_o[0]}); end
      core_req = 1'b0; mem_rdata = 32'h0;
      tick();
      n_checks++; if ({core_done_o[0], busy_o[0]} !== 2'b00) begin
         n_fail++; $display("FAIL rd_idle: got %b want 00", {core_done_o[0], busy_o[0]}); end
      n_checks++; if (core_rdata_o[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold: got %h want deadbeef", core_rdata_o[0]); end
   endtask

   task automatic test_dbg_write();
      do_reset();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h24; mem_rdata = 32'hCAFEF00D;
      tick(); tick();
      n_checks++; if ({dbg_done_o[0], dbg_rdata_o[0]} !== {1'b1, 32'hCAFEF00D}) begin
         n_fail++; $display("FAIL dbg_rd: got done %b data %h want 1 cafef00d", dbg_done_o[0], dbg_rdata_o[0]); end
      dbg_req = 1'b0;
      tick();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678; mem_rdata = 32'h55555555;
      tick();
      n_checks++; if ({mem_en_o[0], mem_we_o[0], dbg_gnt_o[0], core_gnt_o[0]} !== 4'b1110) begin
         n_fail++; $display("FAIL wr_ctrl: got %b want 1110", {mem_en_o[0], mem_we_o[0], dbg_gnt_o[0], core_gnt_o[0]}); end
      n_checks++; if (mem_addr_o[0] !== 32'h20) begin n_fail++; $display("FAIL wr_addr: got %h want 20", mem_addr_o[0]); end
      n_checks++; if (mem_wdata_o[0] !== 32'h12345678) begin n_fail++; $display("FAIL wr_wdata: got %h want 12345678", mem_wdata_o[0]); end
      tick();
      n_checks++; if ({dbg_done_o[0], core_done_o[0], core_gnt_o[0], mem_en_o[0]} !== 4'b1000) begin
         n_fail++; $display("FAIL wr_done: got %b want 1000", {dbg_done_o[0], core_done_o[0], core_gnt_o[0], mem_en_o[0]}); end
      n_checks++; if (dbg_rdata_o[0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want cafef00d", dbg_rdata_o[0]); end
      dbg_req = 1'b0; dbg_we = 1'b0;
      tick();
   endtask

   task automatic test_contention(input int idx, input int lat);
      int   ncnt;
      int   gcyc [4];
      logic gown [4];
      logic pc, pd, overlap;
      rst_n = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
      dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h200;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      ncnt = 0; pc = 1'b0; pd = 1'b0; overlap = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if ((core_gnt_o[idx] && dbg_gnt_o[idx]) || (core_done_o[idx] && dbg_done_o[idx])) overlap = 1'b1;
         if (ncnt < 4 && core_gnt_o[idx] && !pc) begin gcyc[ncnt] = c; gown[ncnt] = 1'b0; ncnt++; end
         if (ncnt < 4 && dbg_gnt_o[idx] && !pd)  begin gcyc[ncnt] = c; gown[ncnt] = 1'b1; ncnt++; end
         pc = core_gnt_o[idx]; pd = dbg_gnt_o[idx];
      end
      n_checks++; if (ncnt != 4) begin n_fail++; $display("FAIL rr_count[lat%0d]: got %0d grants want 4", lat, ncnt); end
      for (int n = 0; n < ncnt; n++) begin
         n_checks++; if (gcyc[n] != 1 + n * (lat + 2)) begin
            n_fail++; $display("FAIL rr_cycle[lat%0d,%0d]: got %0d want %0d", lat, n, gcyc[n], 1 + n * (lat + 2)); end
         n_checks++; if (gown[n] !== n[0]) begin
            n_fail++; $display("FAIL rr_owner[lat%0d,%0d]: got %b want %b", lat, n, gown[n], n[0]); end
      end
      n_checks++; if (overlap !== 1'b0) begin n_fail++; $display("FAIL rr_overlap[lat%0d]: got 1 want 0", lat); end
      core_req = 1'b0; dbg_req = 1'b0;
   endtask

   task automatic test_latency();
      int          en_cnt, busy_cnt, done_at;
      logic [31:0] rd;
      do_reset();
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h30;
      en_cnt = 0; busy_cnt = 0; done_at = 0; rd = '0;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (mem_en_o[2]) en_cnt++;
         if (busy_o[2]) busy_cnt++;
         if (core_done_o[2]) begin done_at = c; rd = core_rdata_o[2]; core_req = 1'b0; end
         mem_rdata = 32'h11111111 * c;
      end
      n_checks++; if (en_cnt != 3) begin n_fail++; $display("FAIL lat_en: got %0d want 3", en_cnt); end
      n_checks++; if (busy_cnt != 4) begin n_fail++; $display("FAIL lat_busy: got %0d want 4", busy_cnt); end
      n_checks++; if (done_at != 4) begin n_fail++; $display("FAIL lat_done: got cycle %0d want 4", done_at); end
      n_checks++; if (rd !== 32'h33333333) begin n_fail++; $display("FAIL lat_rdata: got %h want 33333333", rd); end
      n_checks++; if (core_rdata_o[2] !== 32'h33333333) begin n_fail++; $display("FAIL lat_hold: got %h want 33333333", core_rdata_o[2]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44; mem_rdata = 32'h99999999;
      tick();
      n_checks++; if (dbg_gnt_o[2] !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %b want 1", dbg_gnt_o[2]); end
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if ({dbg_gnt_o[2], mem_en_o[2], busy_o[2], dbg_done_o[2], core_gnt_o[2]} !== 5'b0) begin
         n_fail++; $display("FAIL rm_async: got %b want 0", {dbg_gnt_o[2], mem_en_o[2], busy_o[2], dbg_done_o[2], core_gnt_o[2]}); end
      n_checks++; if ((mem_addr_o[2] | dbg_rdata_o[2]) !== 32'h0) begin
         n_fail++; $display("FAIL rm_async_data: got addr %h rdata %h want 0", mem_addr_o[2], dbg_rdata_o[2]); end
      core_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++; if ({dbg_done_o[2], busy_o[2]} !== 2'b00) begin
            n_fail++; $display("FAIL rm_nodone[%0d]: got %b want 00", c, {dbg_done_o[2], busy_o[2]}); end
      end
      rst_n = 1'b1;
      tick();
      n_checks++; if ({core_gnt_o[2], dbg_gnt_o[2]} !== 2'b10) begin
         n_fail++; $display("FAIL rm_tie: got core/dbg gnt %b want 10", {core_gnt_o[2], dbg_gnt_o[2]}); end
      n_checks++; if (dbg_rdata_o[2] !== 32'h0) begin n_fail++; $display("FAIL rm_rdata: got %h want 0", dbg_rdata_o[2]); end
      core_req = 1'b0; dbg_req = 1'b0;
   endtask

   task automatic test_field_stability();
      do_reset();
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; mem_rdata = 32'hA5A5A5A5;
      tick();
      n_checks++; if ({mem_en_o[1], mem_addr_o[1]} !== {1'b1, 32'h10}) begin
         n_fail++; $display("FAIL fs_c1: got en %b addr %h want 1 10", mem_en_o[1], mem_addr_o[1]); end
      core_addr = 32'h40; core_we = 1'b1; core_wdata = 32'hFFFF0000;
      tick();
      n_checks++; if ({mem_en_o[1], mem_we_o[1], mem_addr_o[1]} !== {2'b10, 32'h10}) begin
         n_fail++; $display("FAIL fs_c2: got en %b we %b addr %h want 1 0 10", mem_en_o[1], mem_we_o[1], mem_addr_o[1]); end
      n_checks++; if (mem_wdata_o[1] !== 32'h0) begin n_fail++; $display("FAIL fs_wdata: got %h want 0", mem_wdata_o[1]); end
      tick();
      n_checks++; if ({core_done_o[1], core_rdata_o[1]} !== {1'b1, 32'hA5A5A5A5}) begin
         n_fail++; $display("FAIL fs_done: got done %b data %h want 1 a5a5a5a5", core_done_o[1], core_rdata_o[1]); end
      core_req = 1'b0; core_we = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_core_read();
      test_dbg_write();
      test_contention(0, 1);
      test_contention(2, 3);
      test_latency();
      test_reset_mid();
      test_field_stability();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (core_*) and a debug/program-loader port (dbg_*).
- Sits between the core datapath and data memory. It sequences each access through an IDLE/ACCESS/DONE state machine and supports a configurable memory latency.
- Fair round-robin arbitration. At most one transaction is outstanding.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles mem_en is held per access (>=1); mem_rdata is valid in the last of them

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req  in  1  core requests an access; held with fields stable until core_done
- core_we  in  1  1=write, 0=read
- core_addr  in  ADDR_W  access address
- core_wdata  in  DATA_W  write data
- core_gnt  out  1  high while core owns the memory (ACCESS state)
- core_done  out  1  one-cycle completion pulse (reads and writes)
- core_rdata  out  DATA_W  read data; valid with core_done, held until the next core read completes
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata: same widths and rules, for the debug port
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0, including both rdata registers; last_owner=DBG.
  - If asserted mid-transaction, the access is abandoned and no done pulse is issued.
  - Leaving reset is synchronous to clk.
- IDLE:
  - At the edge where any req=1, the arbiter picks the owner and latches that owner's we/addr/wdata. state->ACCESS and cnt=MEM_LAT-1.
  - Only one req: that requester wins.
  - Both req: the requester that is not last_owner wins (round-robin). After reset the core wins the first tie.
  - Owner is recorded into last_owner at grant.
- ACCESS:
  - mem_en=1; mem_we/mem_addr/mem_wdata driven from latched fields; owner's gnt=1; other gnt=0.
  - cnt decrements each cycle.
  - In the cycle cnt==0: if the access is a read, mem_rdata is captured into the owner's rdata register. state->DONE.
  - mem_* outputs are 0 when not in ACCESS.
- DONE:
  - The owner's done is 1 for exactly this cycle. state->IDLE.
  - No arbitration happens in DONE. A req still high at the next IDLE edge is a new request.
- Timing and fairness:
  - Latency: req sampled at edge k -> ACCESS cycles k+1..k+MEM_LAT -> done in cycle k+MEM_LAT+1.
  - Minimum spacing between grants is MEM_LAT+2 cycles.
- Writes: rdata register unchanged; done still pulses.
- Requester drops req during ACCESS/DONE (protocol violation): the transaction completes normally. Later input changes are ignored because fields are latched.
- The non-owner's req held during a transaction waits. Under continuous contention it is guaranteed the next grant.
- gnt and done are never high for both ports in the same cycle.

Test Plan:
- Core read alone (MEM_LAT=1): core_req=1, core_we=0, core_addr=0x10, memory returns 0xDEADBEEF -> mem_en high 1 cycle with mem_addr=0x10; core_done pulses 2 cycles after the req edge; core_rdata=0xDEADBEEF.
- Debug write alone: dbg_we=1, dbg_addr=0x20, dbg_wdata=0x12345678 -> mem_we=1 with that addr/data for MEM_LAT cycles; dbg_done pulses; dbg_rdata unchanged; core_gnt stays 0.
- Contention round-robin: both req held continuously from reset exit -> grants alternate core, dbg, core, dbg. Grant-to-grant spacing is MEM_LAT+2 cycles; no overlap of gnt or done.
- Latency parameter: MEM_LAT=3, core read -> mem_en high exactly 3 cycles; rdata captured from mem_rdata in the 3rd cycle; core_done pulses in cycle 4 after the req edge; busy high for 4 cycles.
- Reset mid-operation: assert rst_n=0 during ACCESS of a dbg read -> all outputs 0 immediately (asynchronous), no dbg_done. After release, a tie grants core first.
- Field stability: change core_addr from 0x10 to 0x40 during ACCESS with MEM_LAT=2 -> mem_addr remains 0x10 for both cycles.
